// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment display data front end.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package seg_pkg;

  localparam int DISP_DIGITS     = 8;
  localparam int DISP_DATA_W     = 32;
  localparam int DISP_INT_DIGITS = 10;

  // Double-dabble correction: a nibble at or above the threshold gets the increment
  // so that the following left shift carries correctly into the next decimal digit.
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_INC    = 4'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } seg_state_t;

endpackage

// File: rtl/bcd_adj_nibble.sv
// Per-digit add-3 correction for the double-dabble converter.
// Latency: purely combinational.
// Backpressure: none.
module bcd_adj_nibble
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  // Add 3 to any digit of 5 or more; 4-bit wrap, never carries into the next digit.
  always_comb begin
    nib_o = (nib_i >= BCD_ADJ_THRESH) ? (nib_i + BCD_ADJ_INC) : nib_i;
  end

endmodule

// File: rtl/seg_bcd_feed.sv
// Display register front end: hex pass-through or sequential binary-to-BCD for the scanner.
// Latency: hex write 1 cycle; decimal write DATA_W+1 cycles to the done pulse.
// Backpressure: none; writes while busy go to a one-deep pending slot, last write wins.
module seg_bcd_feed
  import seg_pkg::*;
#(
  parameter int DATA_W     = DISP_DATA_W,
  parameter int DIGITS     = DISP_DIGITS,
  parameter int INT_DIGITS = DISP_INT_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  wr_dec,
  output logic [DIGITS*4-1:0]   disp_data,
  output logic                  disp_ovf,
  output logic                  busy,
  output logic                  done
);

  localparam int BCD_W = INT_DIGITS * 4;
  localparam int OUT_W = DIGITS * 4;
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  seg_state_t          state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                pend_valid_q, pend_valid_d;
  logic [DATA_W-1:0]   pend_data_q, pend_data_d;
  logic                pend_dec_q, pend_dec_d;
  logic [OUT_W-1:0]    disp_data_q, disp_data_d;
  logic                disp_ovf_q, disp_ovf_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [BCD_W+DATA_W-1:0] shifted;
  logic                    svc_vld;
  logic [DATA_W-1:0]       svc_data;
  logic                    svc_dec;

  // Digit corrections applied to the whole BCD accumulator before each shift.
  for (genvar g = 0; g < INT_DIGITS; g++) begin : g_adj
    bcd_adj_nibble u_adj (
      .nib_i (bcd_q[g*4 +: 4]),
      .nib_o (bcd_adj[g*4 +: 4])
    );
  end

  // Next-state logic: write servicing, pending capture, conversion stepping, result publish.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bcd_d        = bcd_q;
    cnt_d        = cnt_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    pend_dec_d   = pend_dec_q;
    disp_data_d  = disp_data_q;
    disp_ovf_d   = disp_ovf_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    shifted      = {bcd_adj, shift_q} << 1;
    svc_vld      = 1'b0;
    svc_data     = wr_data;
    svc_dec      = wr_dec;

    case (state_q)
      IDLE: begin
        // A held write is serviced first; a new write arriving meanwhile takes its slot.
        if (pend_valid_q) begin
          svc_vld      = 1'b1;
          svc_data     = pend_data_q;
          svc_dec      = pend_dec_q;
          pend_valid_d = wr_en;
          if (wr_en) begin
            pend_data_d = wr_data;
            pend_dec_d  = wr_dec;
          end
        end else begin
          svc_vld = wr_en;
        end
      end

      CONV: begin
        if (wr_en) begin
          pend_valid_d = 1'b1;
          pend_data_d  = wr_data;
          pend_dec_d   = wr_dec;
        end
        bcd_d   = shifted[BCD_W+DATA_W-1:DATA_W];
        shift_d = shifted[DATA_W-1:0];
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          busy_d  = 1'b0;
        end
      end

      DONE: begin
        disp_data_d = bcd_q[OUT_W-1:0];
        disp_ovf_d  = |bcd_q[BCD_W-1:OUT_W];
        done_d      = 1'b1;
        state_d     = IDLE;
        // A pending decimal write restarts at once; a pending hex write must wait one
        // cycle because disp_data is already being updated with this result.
        if (pend_valid_q && pend_dec_q) begin
          svc_vld      = 1'b1;
          svc_data     = pend_data_q;
          svc_dec      = 1'b1;
          pend_valid_d = wr_en;
        end else if (wr_en) begin
          pend_valid_d = 1'b1;
        end
        if (wr_en) begin
          pend_data_d = wr_data;
          pend_dec_d  = wr_dec;
        end
      end

      default: state_d = IDLE;
    endcase

    if (svc_vld) begin
      if (svc_dec) begin
        shift_d = svc_data;
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = CONV;
        busy_d  = 1'b1;
      end else begin
        disp_data_d = svc_data[OUT_W-1:0];
        disp_ovf_d  = 1'b0;
        done_d      = 1'b1;
      end
    end
  end

  // State and output registers with synchronous reset; reset aborts any conversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      pend_dec_q   <= 1'b0;
      disp_data_q  <= '0;
      disp_ovf_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bcd_q        <= bcd_d;
      cnt_q        <= cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      pend_dec_q   <= pend_dec_d;
      disp_data_q  <= disp_data_d;
      disp_ovf_q   <= disp_ovf_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign disp_data = disp_data_q;
  assign disp_ovf  = disp_ovf_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_seg_bcd_feed.sv
// Directed bench for seg_bcd_feed: reset, hex and decimal writes, overflow, pending, reset abort.
// Latency: checks exact done timing (1 cycle hex, 33 cycles decimal).
// Backpressure: exercises writes landing in the pending slot while converting.
module tb_seg_bcd_feed;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        wr_dec;
  logic [31:0] disp_data;
  logic        disp_ovf;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seg_bcd_feed u_dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .wr_dec    (wr_dec),
    .disp_data (disp_data),
    .disp_ovf  (disp_ovf),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [31:0] d, input logic dec);
    wr_en   = en;
    wr_data = d;
    wr_dec  = dec;
  endtask

  // Steps until done is seen (bounded); n = number of steps taken.
  task automatic wait_done(output int n, output bit seen);
    n = 0;
    seen = 0;
    while (!seen && n < 100) begin
      if (done) seen = 1;
      else begin
        step();
        n++;
      end
    end
  endtask

  // Decimal write, checking latency, busy span, output hold, result and single-cycle done.
  task automatic dec_write(input string tag, input logic [31:0] v,
                           input logic [31:0] exp_d, input logic exp_o);
    logic [31:0] prev;
    int lat, bcnt, herr;
    bit seen;
    prev = disp_data;
    drive(1'b1, v, 1'b1);
    step();
    drive(1'b0, 32'h0, 1'b0);
    lat = 0; bcnt = 0; herr = 0; seen = 0;
    while (!seen && lat < 100) begin
      if (done) seen = 1;
      else begin
        if (busy) bcnt++;
        if (disp_data !== prev) herr++;
        step();
        lat++;
      end
    end
    chk({tag, "_seen"}, 64'(seen), 64'd1);
    chk({tag, "_lat"},  64'(lat),  64'd33);
    chk({tag, "_busy"}, 64'(bcnt), 64'd32);
    chk({tag, "_hold"}, 64'(herr), 64'd0);
    chk({tag, "_data"}, 64'(disp_data), 64'(exp_d));
    chk({tag, "_ovf"},  64'(disp_ovf), 64'(exp_o));
    step();
    chk({tag, "_done1"}, 64'(done), 64'd0);
  endtask

  initial begin
    int n, errs;
    bit seen;
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_data", 64'(disp_data), 64'h0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ovf",  64'(disp_ovf), 64'd0);

    dec_write("d12345678", 32'd12345678, 32'h12345678, 1'b0);
    dec_write("dffffffff", 32'hFFFF_FFFF, 32'h94967295, 1'b1);
    dec_write("d0",        32'd0,         32'h00000000, 1'b0);
    dec_write("d99999999", 32'd99999999,  32'h99999999, 1'b0);
    dec_write("d1e8",      32'd100000000, 32'h00000000, 1'b1);

    // Hex write from idle: one-cycle latency, no busy.
    drive(1'b1, 32'hDEAD_BEEF, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b0);
    chk("hex_data", 64'(disp_data), 64'hDEADBEEF);
    chk("hex_done", 64'(done), 64'd1);
    chk("hex_busy", 64'(busy), 64'd0);
    chk("hex_ovf",  64'(disp_ovf), 64'd0);
    step();
    chk("hex_done1", 64'(done), 64'd0);
    chk("hex_busy1", 64'(busy), 64'd0);

    // Pending: decimal 100, then decimal 200 and hex 0xABCD during conversion.
    drive(1'b1, 32'd100, 1'b1);
    step();
    drive(1'b0, 32'h0, 1'b0);
    repeat (4) step();
    drive(1'b1, 32'd200, 1'b1);
    step();
    drive(1'b0, 32'h0, 1'b0);
    repeat (2) step();
    drive(1'b1, 32'h0000_ABCD, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b0);
    chk("pend_hold", 64'(disp_data), 64'hDEADBEEF);
    wait_done(n, seen);
    chk("pend_seen", 64'(seen), 64'd1);
    chk("pend_lat",  64'(8 + n), 64'd33);
    chk("pend_d100", 64'(disp_data), 64'h00000100);
    step();
    chk("pend_hex",  64'(disp_data), 64'h0000ABCD);
    chk("pend_hdone", 64'(done), 64'd1);
    chk("pend_hbusy", 64'(busy), 64'd0);
    errs = 0;
    repeat (40) begin
      step();
      if (busy !== 1'b0 || done !== 1'b0 || disp_data !== 32'h0000ABCD) errs++;
    end
    chk("pend_no200", 64'(errs), 64'd0);

    // Reset ten cycles into a conversion aborts it and clears the display.
    drive(1'b1, 32'd99999999, 1'b1);
    step();
    drive(1'b0, 32'h0, 1'b0);
    repeat (9) step();
    chk("abort_busy_pre", 64'(busy), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_data", 64'(disp_data), 64'h0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    errs = 0;
    repeat (40) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0) errs++;
    end
    chk("abort_quiet", 64'(errs), 64'd0);
    dec_write("d7", 32'd7, 32'h00000007, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
